// File: rtl/char_argmin_pack_pkg.sv
// char_argmin_pack_pkg: shared widths, reject code and FSM encoding for the plate frame assembler
package char_argmin_pack_pkg;
  localparam int NUM_CHAR_DEF = 7;
  localparam int IDX_W_DEF = 4;
  localparam int DIFF_W_DEF = 16;
  localparam logic [IDX_W_DEF-1:0] REJECT_IDX = '1;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_EMIT    = 2'd2
  } state_e;
endpackage

// File: rtl/char_argmin_pack_slot.sv
// char_argmin_slot: running minimum-difference tracker for the character slot being collected
module char_argmin_slot #(
  parameter int IDX_W = 4,
  parameter int DIFF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              take_i,
  input  logic              last_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DIFF_W-1:0] diff_i,
  output logic [IDX_W-1:0]  best_idx_o,
  output logic [DIFF_W-1:0] best_diff_o
);
  logic              first_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DIFF_W-1:0] diff_q;
  logic              upd;
  // a clear in the same cycle as a beat makes that beat the slot's first candidate
  assign upd = take_i && (first_q || clear_i || diff_i < diff_q);
  assign best_idx_o = upd ? idx_i : idx_q;
  assign best_diff_o = upd ? diff_i : diff_q;
  // best-so-far registers; the first-beat flag re-arms after each slot's last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= 1'b1;
      idx_q <= '0;
      diff_q <= '0;
    end else begin
      first_q <= take_i ? last_i : (clear_i ? 1'b1 : first_q);
      idx_q <= best_idx_o;
      diff_q <= best_diff_o;
    end
  end
endmodule

// File: rtl/char_argmin_pack.sv
// char_argmin_pack: per-slot argmin over candidate beats, packed into one frame per NUM_CHAR slots (CHAR_REJECT_EN enables the over-threshold reject code)
module char_argmin_pack
  import char_argmin_pack_pkg::*;
#(
  parameter int NUM_CHAR = NUM_CHAR_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int DIFF_W = DIFF_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_start,
  input  logic                       cand_valid,
  output logic                       cand_ready,
  input  logic [IDX_W-1:0]           cand_index,
  input  logic [DIFF_W-1:0]          cand_diff,
  input  logic                       cand_last,
  input  logic [DIFF_W-1:0]          max_diff,
  output logic [NUM_CHAR*IDX_W-1:0]  char_index_c,
  output logic [NUM_CHAR*DIFF_W-1:0] char_diff_c,
  output logic                       char_valid_c
);
  localparam int SW = $clog2(NUM_CHAR + 1);
  state_e                     state_q;
  logic [SW-1:0]              slot_q;
  logic [SW-1:0]              commit_slot;
  logic [IDX_W-1:0]           slot_idx_q [NUM_CHAR];
  logic [IDX_W-1:0]           slot_idx_d [NUM_CHAR];
  logic [DIFF_W-1:0]          slot_diff_q [NUM_CHAR];
  logic [DIFF_W-1:0]          slot_diff_d [NUM_CHAR];
  logic [IDX_W-1:0]           best_idx;
  logic [IDX_W-1:0]           store_idx;
  logic [DIFF_W-1:0]          best_diff;
  logic [NUM_CHAR*IDX_W-1:0]  pack_idx;
  logic [NUM_CHAR*DIFF_W-1:0] pack_diff;
  logic                       accept;
  logic                       commit;
  logic                       frame_done;
  assign cand_ready = state_q != S_EMIT;
  assign accept = cand_valid && cand_ready;
  assign commit = accept && cand_last;
  assign commit_slot = frame_start ? '0 : slot_q;
  assign frame_done = commit && commit_slot == SW'(NUM_CHAR - 1);
  char_argmin_slot #(.IDX_W(IDX_W), .DIFF_W(DIFF_W)) u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (frame_start),
    .take_i     (accept),
    .last_i     (cand_last),
    .idx_i      (cand_index),
    .diff_i     (cand_diff),
    .best_idx_o (best_idx),
    .best_diff_o(best_diff)
  );
`ifdef CHAR_REJECT_EN
  assign store_idx = best_diff > max_diff ? {IDX_W{1'b1}} : best_idx;
`else
  logic unused_max_diff;
  assign unused_max_diff = ^max_diff;
  assign store_idx = best_idx;
`endif
  // slot array with this cycle's commit folded in, so the final slot can be packed on its own commit edge
  always_comb begin
    slot_idx_d = slot_idx_q;
    slot_diff_d = slot_diff_q;
    pack_idx = '0;
    pack_diff = '0;
    if (commit) begin
      slot_idx_d[commit_slot] = store_idx;
      slot_diff_d[commit_slot] = best_diff;
    end
    for (int k = 0; k < NUM_CHAR; k++) begin
      pack_idx[(NUM_CHAR-k)*IDX_W-1 -: IDX_W] = slot_idx_d[k];
      pack_diff[(NUM_CHAR-k)*DIFF_W-1 -: DIFF_W] = slot_diff_d[k];
    end
  end
  // frame FSM with slot counter, slot storage and registered frame outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      slot_q <= '0;
      char_index_c <= '0;
      char_diff_c <= '0;
      char_valid_c <= 1'b0;
      for (int k = 0; k < NUM_CHAR; k++) begin
        slot_idx_q[k] <= '0;
        slot_diff_q[k] <= '0;
      end
    end else begin
      slot_idx_q <= slot_idx_d;
      slot_diff_q <= slot_diff_d;
      char_valid_c <= frame_done;
      char_index_c <= frame_done ? pack_idx : char_index_c;
      char_diff_c <= frame_done ? pack_diff : char_diff_c;
      if (state_q == S_EMIT) begin
        state_q <= frame_start ? S_COLLECT : S_IDLE;
        slot_q <= '0;
      end else begin
        state_q <= frame_done ? S_EMIT : ((frame_start || accept) ? S_COLLECT : state_q);
        slot_q <= commit ? commit_slot + SW'(1) : (frame_start ? '0 : slot_q);
      end
    end
  end
endmodule
